// File: rtl/data_mem_responder_if.sv
// Initiator/responder bus for the data memory responder.
// The initiator drives req/we/addr/wdata; the responder returns rdata/ready/err.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data memory responder with range checking.
// Optional: define DMEM_MISALIGN_TRAP_EN to fault accesses with addr[1:0] != 0.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          LATENCY     = 2
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  counter;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic        err_pend;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic [31:0] byte_off;
  logic [31:0] word_off;
  logic [IDX_W-1:0] idx;
  logic        fault;
  logic        enter_resp;

  // With zero latency the access completes on its sample edge, so the live bus is used in IDLE.
  always_comb begin
    acc_addr  = (state == IDLE) ? bus.addr  : lat_addr;
    acc_wdata = (state == IDLE) ? bus.wdata : lat_wdata;
    acc_we    = (state == IDLE) ? bus.we    : lat_we;
    byte_off  = acc_addr - BASE_ADDR;
    word_off  = byte_off >> 2;
    idx       = word_off[IDX_W-1:0];
    fault     = (acc_addr < BASE_ADDR) || (word_off >= 32'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
    fault     = fault || (acc_addr[1:0] != 2'b00);
`else
    fault     = fault;
`endif
    enter_resp = 1'b0;
    if (state == IDLE) begin
      enter_resp = bus.req && (LATENCY == 0);
    end else if (state == WAIT) begin
      enter_resp = (counter == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !fault) begin
      mem[idx] <= acc_wdata;
    end
  end

  // ready/err are issued on the cycle after RESP so they land LATENCY+1 edges after the sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_we    <= 1'b0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_pend  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (enter_resp) begin
        rdata_q  <= (fault || acc_we) ? 32'd0 : mem[idx];
        err_pend <= fault;
      end
      case (state)
        IDLE: begin
          if (bus.req) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_we    <= bus.we;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              counter <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (counter == 4'd0) begin
            state <= RESP;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          err_q   <= err_pend;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance driven with directed and
// random accesses against a word-array model, plus a LATENCY=0 instance with req held high.
module tb_data_mem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h10010000;

  typedef struct {
    int          cyc;
    logic        err;
    logic        chk_data;
    logic [31:0] rdata;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   compared   = 0;
  int   mismatched = 0;

  exp_t        sb[$];
  exp_t        mon_entry;
  logic [31:0] model_mem [int];

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: a word array indexed by (addr-BASE)/4 with range and alignment rules.
  function automatic exp_t model_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   bad;
    int   widx;
    bad = (a < BASE) || (((a - BASE) / 4) >= DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % 4) != 0) bad = 1'b1;
`endif
    e.cyc      = 0;
    e.err      = bad;
    e.chk_data = 1'b1;
    e.rdata    = 32'd0;
    if (!bad) begin
      widx = int'((a - BASE) / 4);
      if (w) model_mem[widx] = d;
      else if (model_mem.exists(widx)) e.rdata = model_mem[widx];
      else e.chk_data = 1'b0;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input bit noise);
    exp_t e;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    e     = model_access(w, a, d);
    e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    repeat (LAT + 1) begin
      @(negedge clk);
      if (noise) begin
        bus.req   = 1'($urandom_range(0, 1));
        bus.we    = 1'($urandom_range(0, 1));
        bus.addr  = $urandom;
        bus.wdata = $urandom;
      end else begin
        bus.req = 1'b0;
      end
    end
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL missing_ready: no ready by cycle %0d, required at cycle %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_ready: ready=1 at cycle %0d, required 0", cyc);
        end else begin
          mon_entry = sb.pop_front();
          checkOutput("ready_cycle", cyc, mon_entry.cyc);
          checkOutput("err", {31'd0, bus.err}, {31'd0, mon_entry.err});
          if (mon_entry.chk_data) checkOutput("rdata", bus.rdata, mon_entry.rdata);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          r;
    bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = 32'd0; bus.wdata  = 32'd0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;

    #12;
    checkOutput("reset_rdata", bus.rdata, 32'd0);
    checkOutput("reset_ready", {31'd0, bus.ready}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
    checkOutput("reset_ready0", {31'd0, bus0.ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, BASE, 32'h0BADF00D, 1'b1);
    applyStimulus(1'b1, BASE + 32'h4, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b0, BASE + 32'h4, 32'd0, 1'b1);
    applyStimulus(1'b0, BASE, 32'd0, 1'b0);
    applyStimulus(1'b1, BASE + 32'h400, 32'hFFFFFFFF, 1'b1);
    applyStimulus(1'b0, BASE, 32'd0, 1'b1);
    applyStimulus(1'b0, BASE - 32'h4, 32'd0, 1'b1);
    applyStimulus(1'b1, BASE + 32'h3FC, 32'hCAFE0001, 1'b1);
    applyStimulus(1'b0, BASE + 32'h3FC, 32'd0, 1'b1);
    applyStimulus(1'b0, BASE + 32'h2, 32'd0, 1'b1);
    applyStimulus(1'b1, BASE + 32'h8, 32'hA5A5A5A5, 1'b1);
    applyStimulus(1'b0, BASE + 32'h4, 32'd0, 1'b1);

    // Abort a write mid-WAIT; rdata still holds the previous DEADBEEF read until reset hits.
    $display("[TB] reset during a pending write");
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = BASE + 32'h8;
    bus.wdata = 32'h12345678;
    @(posedge clk);
    #2;
    bus.req = 1'b0;
    reset   = 1'b0;
    #1;
    checkOutput("midreset_rdata", bus.rdata, 32'd0);
    checkOutput("midreset_ready", {31'd0, bus.ready}, 32'd0);
    checkOutput("midreset_err", {31'd0, bus.err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, BASE + 32'h8, 32'd0, 1'b1);

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = BASE + 32'($urandom_range(0, 15)) * 4 + ((r == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      else if (r == 7) a = BASE + 32'(DEPTH) * 4 + 32'($urandom_range(0, 15)) * 4;
      else if (r == 8) a = BASE - 32'($urandom_range(1, 8)) * 4;
      else a = BASE + 32'(DEPTH) * 4 - 32'h4;
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(LAT + 4);

    $display("[TB] zero latency with req held");
    bus0.req   = 1'b1;
    bus0.we    = 1'b1;
    bus0.addr  = BASE;
    bus0.wdata = $urandom;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checkOutput("zl_ready", {31'd0, bus0.ready}, 32'(n % 2));
      if ((n % 2) == 1) begin
        checkOutput("zl_err", {31'd0, bus0.err}, 32'd0);
        checkOutput("zl_rdata", bus0.rdata, 32'd0);
      end
    end
    bus0.req = 1'b0;
    idle_cycles(3);

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL pending_responses: %0d outstanding, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10010000, giving the byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, giving wait cycles before a response (range 0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  initiator access request.
REQ-007 SHALL have port we  input  1  access is a write when 1, a read when 0.
REQ-008 SHALL have port addr  input  32  byte address (datapath ALU result).
REQ-009 SHALL have port wdata  input  32  store data.
REQ-010 SHALL have port rdata  output  32  load data, registered.
REQ-011 SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port err  output  1  access-fault flag, valid only with ready.

Function
REQ-013 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, SHALL latch addr, we and wdata, then go to WAIT with counter=LATENCY-1, or to RESP if LATENCY=0.
REQ-015 In WAIT, SHALL decrement the counter each cycle and go to RESP when the counter is 0.
REQ-016 In RESP, SHALL drive ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-017 ready SHALL rise LATENCY+1 cycles after the edge on which req was sampled in IDLE.
REQ-018 req, we, addr and wdata SHALL be ignored outside IDLE; a req drop in WAIT does not abort the access.
REQ-019 A req still high in the IDLE cycle after RESP SHALL start a new access; the minimum spacing is LATENCY+2 cycles.
REQ-020 Word index SHALL be (latched addr - BASE_ADDR) >> 2.
REQ-021 Out of range is defined as index >= DEPTH_WORDS or addr < BASE_ADDR.
REQ-022 An out-of-range access SHALL produce err=1 and rdata=0, and SHALL NOT write memory.
REQ-023 A write SHALL update the memory word on the edge entering RESP and SHALL set rdata=0.
REQ-024 A read SHALL load rdata with the memory word on the edge entering RESP.
REQ-025 rdata SHALL hold its value until the next response.
REQ-026 A read issued immediately after a write to the same word SHALL return the new data.
REQ-027 The storage array SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, counter=0, ready=0, err=0 and rdata=0, independent of clk.
REQ-029 Reset asserted mid-access SHALL discard the pending access; no memory write and no ready occur.
REQ-030 The first req SHALL be sampled on the first rising edge after reset deasserts.

Configuration
REQ-031 With DMEM_MISALIGN_TRAP_EN defined, an access with addr[1:0]!=0 SHALL complete with err=1, no write and rdata=0, at normal latency.
REQ-032 With DMEM_MISALIGN_TRAP_EN undefined, addr[1:0] SHALL be ignored and the access SHALL proceed as word-aligned.

Verification
REQ-033 Check write then read back.
- Stimulus: LATENCY=2; write 32'hDEADBEEF to 0x10010004, then read 0x10010004.
- Response: ready in cycle 3 after each sample; rdata=32'hDEADBEEF; err=0.
REQ-034 Check request drop during WAIT.
- Stimulus: LATENCY=2; req dropped after one cycle during a read of 0x10010000.
- Response: ready still pulses once, 3 cycles after the sample.
REQ-035 Check out-of-range write.
- Stimulus: write to 0x10010400 with DEPTH_WORDS=256.
- Response: ready with err=1 and rdata=0; a later read of 0x10010000 is unchanged.
REQ-036 Check misaligned access.
- Stimulus: read 0x10010002.
- Response: with DMEM_MISALIGN_TRAP_EN, err=1 and rdata=0; without it, err=0 and rdata=word 0.
REQ-037 Check reset mid-access.
- Stimulus: reset=0 pulsed mid-WAIT during a write of 32'h12345678 to 0x10010008.
- Response: outputs go to 0 immediately, no ready; a later read does not return 32'h12345678.
REQ-038 Check zero latency with held req.
- Stimulus: LATENCY=0, req held high.
- Response: ready pulses every second cycle with alternating IDLE and RESP states.
